// File: rtl/mem_pkg.sv
// Shared types and defaults for the mem_slave block: state enum, width defaults
// taken from the WIDTH / ADDR_WIDTH macros, and the storage depth helper.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package mem_pkg;

  localparam int DEF_WIDTH      = `WIDTH;
  localparam int DEF_ADDR_WIDTH = `ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_slave: one synchronous write port, a combinational
// read of the same address, and a synchronous clear of every word.
module mem_array
  import mem_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = depth(ADDR_WIDTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  // Clear has priority so a reset in the commit cycle leaves nothing behind.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[addr] <= wdata;
    end
  end

  assign rdata = mem_reg[addr];

endmodule

// File: rtl/mem_slave.sv
// Single-outstanding memory slave: latches a request, optionally waits
// WAIT_CYCLES cycles (macro MEM_WAIT_EN), then completes with a ready pulse.
module mem_slave
  import mem_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("WAIT_CYCLES must be at least 1");
  end

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    wr_reg;
  logic [WIDTH-1:0]        wdata_reg;
  logic [WIDTH-1:0]        rdata_reg;
  logic                    ready_reg;
  logic [WIDTH-1:0]        mem_rdata;
  logic                    mem_we;

`ifdef MEM_WAIT_EN
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
`endif

  always_comb begin
    state_next = state_reg;
`ifdef MEM_WAIT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (valid) begin
`ifdef MEM_WAIT_EN
          state_next    = WAIT;
          wait_cnt_next = CW'(WAIT_CYCLES - 1);
`else
          state_next = RESP;
`endif
        end
      end
`ifdef MEM_WAIT_EN
      WAIT: begin
        if (wait_cnt_reg == '0) begin
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - 1'b1;
        end
      end
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Commit happens on the edge leaving RESP; ready and read data are
  // registered on that same edge so they appear together in the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wr_reg    <= 1'b0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
`ifdef MEM_WAIT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_reg == RESP);
`ifdef MEM_WAIT_EN
      wait_cnt_reg <= wait_cnt_next;
`endif
      if (state_reg == IDLE && valid) begin
        addr_reg  <= addr;
        wr_reg    <= wr_rd;
        wdata_reg <= wdata;
      end
      if (state_reg == RESP && !wr_reg) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_we = (state_reg == RESP) && wr_reg;

  mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk   (clk),
    .clr   (rst),
    .we    (mem_we),
    .addr  (addr_reg),
    .wdata (wdata_reg),
    .rdata (mem_rdata)
  );

  assign ready = ready_reg;
  assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_slave.sv
// Self-checking bench for mem_slave: a transaction-level reference model is
// compared every cycle, plus directed transactions with literal expectations.
module tb_mem_slave;

  localparam int W  = 32;
  localparam int AW = 8;
  localparam int WC = 3;
`ifdef MEM_WAIT_EN
  localparam int LAT = 1 + WC;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          wr_rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic          ready;
  logic [W-1:0]  rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_slave #(
    .WIDTH       (W),
    .ADDR_WIDTH  (AW),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .wr_rd (wr_rd),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .rdata (rdata)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a request accepted at edge N completes at edge N+LAT,
  // where the write lands or the read value appears, and ready follows.
  logic [W-1:0]  m_mem [1 << AW];
  bit            m_pend = 0;
  int            m_done = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [W-1:0]  m_wdata = '0;
  bit            exp_ready = 0;
  logic [W-1:0]  exp_rdata = '0;
  bit            m_init = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_pend    = 0;
      exp_ready = 0;
      exp_rdata = '0;
      m_init    = 1;
    end else begin
      exp_ready = 0;
      if (m_pend && cyc == m_done) begin
        exp_ready = 1;
        m_pend    = 0;
        if (m_wr) m_mem[m_addr] = m_wdata;
        else      exp_rdata = m_mem[m_addr];
      end else if (!m_pend && valid) begin
        m_pend  = 1;
        m_done  = cyc + LAT;
        m_wr    = wr_rd;
        m_addr  = addr;
        m_wdata = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("ready", {31'd0, ready}, {31'd0, exp_ready});
      chk("rdata", rdata, exp_rdata);
    end
  end

  // One request; afterwards the bus is scrambled to prove the latch holds.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                     output logic [W-1:0] rd, output int lat);
    int n;
    lat = -1;
    rd  = '0;
    @(posedge clk); #1;
    valid = 1'b1; wr_rd = wr; addr = a; wdata = d;
    n = cyc + 1;
    @(posedge clk); #1;
    valid = 1'b0; wr_rd = ~wr; addr = a + 1'b1; wdata = 32'h99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = cyc - n;
        rd  = rdata;
        break;
      end
    end
    $display("txn %s addr=%h wdata=%h rdata=%h latency=%0d", wr ? "WR" : "RD", a, d, rd, lat);
  endtask

  initial begin
    logic [W-1:0] rd;
    int lat, pulses, first, second;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset contents
    txn(0, 8'h05, '0, rd, lat);
    chk("rst_read_data", rd, 32'h0);
    chk("rst_read_lat", W'(lat), W'(LAT));

    // Write then read
    txn(1, 8'h0A, 32'hDEADBEEF, rd, lat);
    chk("wr_lat", W'(lat), W'(LAT));
    txn(0, 8'h0A, '0, rd, lat);
    chk("raw_data", rd, 32'hDEADBEEF);

    // Bus changes after acceptance: addr->0x07, wdata->0x99
    txn(1, 8'h06, 32'h44, rd, lat);
    txn(0, 8'h06, '0, rd, lat);
    chk("latch_data", rd, 32'h44);
    txn(0, 8'h07, '0, rd, lat);
    chk("latch_other_addr", rd, 32'h0);

    // Back-to-back with valid held high
    @(posedge clk); #1;
    valid = 1'b1; wr_rd = 1'b1; addr = 8'h01; wdata = 32'h11;
    @(posedge clk); #1;
    addr = 8'h02; wdata = 32'h22;
    pulses = 0; first = -1; second = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready) begin
        pulses++;
        if (pulses == 1) begin
          first = cyc;
          @(posedge clk); #1;
          valid = 1'b0;
        end else begin
          second = cyc;
        end
      end
    end
    $display("txn B2B pulses=%0d first=%0d second=%0d", pulses, first, second);
    chk("b2b_pulses", W'(pulses), 32'd2);
    chk("b2b_gap", W'(second - first), W'(LAT + 1));
    txn(0, 8'h01, '0, rd, lat);
    chk("b2b_read1", rd, 32'h11);
    txn(0, 8'h02, '0, rd, lat);
    chk("b2b_read2", rd, 32'h22);

    // Reset in the cycle after acceptance drops the transaction
    @(posedge clk); #1;
    valid = 1'b1; wr_rd = 1'b1; addr = 8'h03; wdata = 32'h55;
    @(posedge clk); #1;
    valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    $display("txn RST_MID pulses=%0d", pulses);
    chk("rst_mid_no_ready", W'(pulses), 32'd0);
    txn(0, 8'h03, '0, rd, lat);
    chk("rst_mid_read", rd, 32'h0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rst   = ($urandom_range(0, 63) == 0);
      valid = 1'($urandom_range(0, 1));
      wr_rd = 1'($urandom_range(0, 1));
      addr  = AW'($urandom_range(0, 15));
      wdata = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
